// File: rtl/controle_emulador_pkg.sv
// controle_pkg: button bit map, phase constants and the pad-pin encoder shared
// by the emulator and the controller reader.
`default_nettype none

package controle_pkg;

   localparam int BIT_UP    = 0;
   localparam int BIT_DOWN  = 1;
   localparam int BIT_LEFT  = 2;
   localparam int BIT_RIGHT = 3;
   localparam int BIT_A     = 4;
   localparam int BIT_B     = 5;
   localparam int BIT_C     = 6;
   localparam int BIT_X     = 7;
   localparam int BIT_Y     = 8;
   localparam int BIT_Z     = 9;
   localparam int BIT_START = 10;
   localparam int BIT_MODE  = 11;

   localparam int TIMEOUT_1MS5 = 75000;

   typedef logic [2:0] fase_t;

   localparam fase_t FASE_ID  = 3'd3;
   localparam fase_t FASE_MAX = 3'd4;

   typedef struct packed {
      logic p1;
      logic p2;
      logic p3;
      logic p4;
      logic p6;
      logic p9;
   } pinos_t;

   // Active-low pad pins for a given Select level and the phase being entered.
   function automatic pinos_t codifica(input logic alto, input fase_t fase,
                                       input logic [11:0] b);
      pinos_t p;
      if (alto) begin
         p.p6 = ~b[BIT_B];
         p.p9 = ~b[BIT_C];
         if (fase == FASE_ID)
            {p.p1, p.p2, p.p3, p.p4} = ~{b[BIT_Z], b[BIT_Y], b[BIT_X], b[BIT_MODE]};
         else
            {p.p1, p.p2, p.p3, p.p4} = ~{b[BIT_UP], b[BIT_DOWN], b[BIT_LEFT], b[BIT_RIGHT]};
      end else begin
         p.p6 = ~b[BIT_A];
         p.p9 = ~b[BIT_START];
         if (fase == FASE_MAX)
            {p.p1, p.p2, p.p3, p.p4} = 4'b1111;
         else if (fase == FASE_ID)
            {p.p1, p.p2, p.p3, p.p4} = 4'b0000;
         else
            {p.p1, p.p2, p.p3, p.p4} = {~b[BIT_UP], ~b[BIT_DOWN], 2'b00};
      end
      return p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/controle_emulador_if.sv
// Pad-side bus: host Select and button vector in, six active-low pad pins out.
`default_nettype none

interface controle_emulador_if;
   logic        Select;
   logic [11:0] Botoes;
   logic        Pino1;
   logic        Pino2;
   logic        Pino3;
   logic        Pino4;
   logic        Pino6;
   logic        Pino9;

   modport master (
      output Select, Botoes,
      input  Pino1, Pino2, Pino3, Pino4, Pino6, Pino9
   );

   modport slave (
      input  Select, Botoes,
      output Pino1, Pino2, Pino3, Pino4, Pino6, Pino9
   );
endinterface

`default_nettype wire

// File: rtl/controle_emulador_sincroniza_borda.sv
// sincroniza_borda: 3-flop synchronizer (reset to 1) with falling/any-edge detect.
`default_nettype none

module sincroniza_borda (
   input  wire logic Clock50,
   input  wire logic Reset,
   input  wire logic entrada,
   output logic      s2,
   output logic      fall,
   output logic      edge_any
);

   logic s1;
   logic s3;

   always_ff @(posedge Clock50) begin
      if (Reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= entrada;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign fall     = s3 & ~s2;
   assign edge_any = s3 ^ s2;

endmodule

`default_nettype wire

// File: rtl/controle_emulador.sv
// controle_emulador: 6/3-button Genesis pad responder driving pad pins from Botoes
// according to the Select falling-edge phase count with idle timeout.
`default_nettype none

module controle_emulador
   import controle_pkg::*;
#(
   parameter int SEIS_BOTOES = 1,
   parameter int TIMEOUT     = TIMEOUT_1MS5
) (
   input wire logic             Clock50,
   input wire logic             Reset,
   controle_emulador_if.slave   pad
);

   localparam logic [16:0] OCIOSO_MAX = 17'(TIMEOUT - 1);
   localparam fase_t       FASE_LIM   = (SEIS_BOTOES != 0) ? FASE_MAX : 3'd2;

   logic        s2;
   logic        fall;
   logic        edge_any;
   fase_t       fase;
   fase_t       fase_next;
   fase_t       fase_base;
   logic [16:0] ocioso;
   logic [16:0] ocioso_next;
   logic        expirou;
   pinos_t      pinos;

   sincroniza_borda u_sinc (
      .Clock50  (Clock50),
      .Reset    (Reset),
      .entrada  (pad.Select),
      .s2       (s2),
      .fall     (fall),
      .edge_any (edge_any)
   );

   // An expiring idle count and a fall in the same cycle count the fall from 0.
   always_comb begin
      expirou     = (ocioso == OCIOSO_MAX);
      fase_base   = expirou ? 3'd0 : fase;
      fase_next   = fase;
      ocioso_next = ocioso;
      if (fall)
         fase_next = (fase_base >= FASE_LIM) ? FASE_LIM : fase_base + 3'd1;
      else if (expirou)
         fase_next = 3'd0;
      if (edge_any)
         ocioso_next = '0;
      else if (!expirou)
         ocioso_next = ocioso + 17'd1;
   end

   always_ff @(posedge Clock50) begin
      if (Reset) begin
         fase   <= 3'd0;
         ocioso <= '0;
         pinos  <= '1;
      end else begin
         fase   <= fase_next;
         ocioso <= ocioso_next;
         pinos  <= codifica(s2, fase_next, pad.Botoes);
      end
   end

   assign pad.Pino1 = pinos.p1;
   assign pad.Pino2 = pinos.p2;
   assign pad.Pino3 = pinos.p3;
   assign pad.Pino4 = pinos.p4;
   assign pad.Pino6 = pinos.p6;
   assign pad.Pino9 = pinos.p9;

endmodule

`default_nettype wire

// File: tb/tb_controle_emulador.sv
// Directed bench for controle_emulador: 6-button and 3-button instances, short TIMEOUT.
`default_nettype none

module tb_controle_emulador;

   localparam int T = 200;
   localparam int L = 20;

   logic Clock50;
   logic Reset;
   int   checks;
   int   failures;

   controle_emulador_if bus6 ();
   controle_emulador_if bus3 ();

   controle_emulador #(.SEIS_BOTOES(1), .TIMEOUT(T)) dut6 (
      .Clock50 (Clock50),
      .Reset   (Reset),
      .pad     (bus6.slave)
   );

   controle_emulador #(.SEIS_BOTOES(0), .TIMEOUT(T)) dut3 (
      .Clock50 (Clock50),
      .Reset   (Reset),
      .pad     (bus3.slave)
   );

   // Pin order {P1,P2,P3,P4,P6,P9}
   logic [5:0] p6;
   logic [5:0] p3;
   assign p6 = {bus6.Pino1, bus6.Pino2, bus6.Pino3, bus6.Pino4, bus6.Pino6, bus6.Pino9};
   assign p3 = {bus3.Pino1, bus3.Pino2, bus3.Pino3, bus3.Pino4, bus3.Pino6, bus3.Pino9};

   always #10 Clock50 = ~Clock50;

   task automatic tick(input int n);
      repeat (n) @(posedge Clock50);
      #1;
   endtask

   task automatic set_in(input logic sel, input logic [11:0] b);
      bus6.Select = sel;
      bus3.Select = sel;
      bus6.Botoes = b;
      bus3.Botoes = b;
   endtask

   task automatic set_sel(input logic sel);
      bus6.Select = sel;
      bus3.Select = sel;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick(2);
      Reset = 1'b0;
   endtask

   task automatic falls_hold(input int n);
      set_sel(1'b0); tick(L);
      set_sel(1'b1); tick(L);
      set_sel(1'b0); tick(L);
      set_sel(1'b1); tick(n);
   endtask

   task automatic test_reset();
      set_in(1'b1, 12'hFFF);
      Reset = 1'b1;
      tick(2);
      checks++;
      if (p6 !== 6'b111111) begin
         failures++;
         $display("FAIL reset_pins actual=%b expected=%b", p6, 6'b111111);
      end
      checks++;
      if (dut6.fase !== 3'd0) begin
         failures++;
         $display("FAIL reset_fase actual=%0d expected=0", dut6.fase);
      end
      Reset = 1'b0;
      tick(1);
      checks++;
      if (p6 !== 6'b000000) begin
         failures++;
         $display("FAIL post_reset actual=%b expected=%b", p6, 6'b000000);
      end
   endtask

   task automatic test_basic();
      set_in(1'b1, 12'h041);
      do_reset();
      tick(3);
      checks++;
      if (p6 !== 6'b011110) begin
         failures++;
         $display("FAIL high_up_c actual=%b expected=%b", p6, 6'b011110);
      end
      set_sel(1'b0);
      tick(2);
      checks++;
      if (p6 !== 6'b011110) begin
         failures++;
         $display("FAIL select_latency actual=%b expected=%b", p6, 6'b011110);
      end
      tick(1);
      checks++;
      if (p6 !== 6'b010011) begin
         failures++;
         $display("FAIL low_phase1 actual=%b expected=%b", p6, 6'b010011);
      end
      set_in(1'b0, 12'h002);
      tick(1);
      checks++;
      if (p6 !== 6'b100011) begin
         failures++;
         $display("FAIL botoes_latency actual=%b expected=%b", p6, 6'b100011);
      end
   endtask

   task automatic test_frame6();
      logic [5:0] exp6 [8];
      exp6 = '{6'b111111, 6'b110001, 6'b111111, 6'b110001,
               6'b111111, 6'b000001, 6'b110011, 6'b111101};
      set_in(1'b1, 12'h890);
      do_reset();
      tick(5);
      for (int ph = 0; ph < 8; ph++) begin
         set_sel((ph % 2) == 0);
         tick(L);
         checks++;
         if (p6 !== exp6[ph]) begin
            failures++;
            $display("FAIL frame6_phase%0d actual=%b expected=%b", ph, p6, exp6[ph]);
         end
      end
      checks++;
      if (dut6.fase !== 3'd4) begin
         failures++;
         $display("FAIL frame6_fase actual=%0d expected=4", dut6.fase);
      end
   endtask

   task automatic test_frame3();
      logic [5:0] e;
      set_in(1'b1, 12'h380);
      do_reset();
      tick(5);
      for (int ph = 0; ph < 8; ph++) begin
         set_sel((ph % 2) == 0);
         tick(L);
         e = ((ph % 2) == 0) ? 6'b111111 : 6'b110011;
         checks++;
         if (p3 !== e) begin
            failures++;
            $display("FAIL frame3_phase%0d actual=%b expected=%b", ph, p3, e);
         end
      end
      checks++;
      if (dut3.fase !== 3'd2) begin
         failures++;
         $display("FAIL frame3_fase actual=%0d expected=2", dut3.fase);
      end
   endtask

   task automatic test_timeout();
      set_in(1'b1, 12'h000);
      do_reset();
      tick(5);
      falls_hold(T - 1);
      set_sel(1'b0);
      tick(3);
      checks++;
      if (dut6.fase !== 3'd3) begin
         failures++;
         $display("FAIL timeout_short_fase actual=%0d expected=3", dut6.fase);
      end
      checks++;
      if (p6 !== 6'b000011) begin
         failures++;
         $display("FAIL timeout_short_pins actual=%b expected=%b", p6, 6'b000011);
      end
      tick(T + 5);
      checks++;
      if (dut6.fase !== 3'd0) begin
         failures++;
         $display("FAIL timeout_idle_fase actual=%0d expected=0", dut6.fase);
      end
      set_sel(1'b1);
      tick(L);
      falls_hold(T);
      set_sel(1'b0);
      tick(3);
      checks++;
      if (dut6.fase !== 3'd1) begin
         failures++;
         $display("FAIL timeout_exact_fase actual=%0d expected=1", dut6.fase);
      end
      checks++;
      if (p6 !== 6'b110011) begin
         failures++;
         $display("FAIL timeout_exact_pins actual=%b expected=%b", p6, 6'b110011);
      end
      set_in(1'b0, 12'h001);
      tick(1);
      checks++;
      if (p6 !== 6'b010011) begin
         failures++;
         $display("FAIL timeout_track_up actual=%b expected=%b", p6, 6'b010011);
      end
      set_in(1'b0, 12'h002);
      tick(1);
      checks++;
      if (p6 !== 6'b100011) begin
         failures++;
         $display("FAIL timeout_track_down actual=%b expected=%b", p6, 6'b100011);
      end
   endtask

   task automatic test_saturate();
      logic [5:0] lo [6];
      logic [5:0] hi [6];
      lo = '{6'b010011, 6'b010011, 6'b000011, 6'b111111, 6'b111111, 6'b111111};
      hi = '{6'b011111, 6'b011111, 6'b111111, 6'b011111, 6'b011111, 6'b011111};
      set_in(1'b1, 12'h001);
      do_reset();
      tick(5);
      for (int k = 0; k < 6; k++) begin
         set_sel(1'b0);
         tick(L);
         checks++;
         if (p6 !== lo[k]) begin
            failures++;
            $display("FAIL sat_low%0d actual=%b expected=%b", k, p6, lo[k]);
         end
         set_sel(1'b1);
         tick(L);
         checks++;
         if (p6 !== hi[k]) begin
            failures++;
            $display("FAIL sat_high%0d actual=%b expected=%b", k, p6, hi[k]);
         end
      end
      checks++;
      if (dut6.fase !== 3'd4) begin
         failures++;
         $display("FAIL sat_fase actual=%0d expected=4", dut6.fase);
      end
      Reset = 1'b1;
      tick(1);
      checks++;
      if (dut6.fase !== 3'd0 || p6 !== 6'b111111) begin
         failures++;
         $display("FAIL midframe_reset actual=%0d/%b expected=0/%b", dut6.fase, p6, 6'b111111);
      end
      Reset = 1'b0;
      tick(1);
      checks++;
      if (p6 !== 6'b011111) begin
         failures++;
         $display("FAIL midframe_first actual=%b expected=%b", p6, 6'b011111);
      end
   endtask

   initial begin
      Clock50  = 1'b0;
      Reset    = 1'b1;
      checks   = 0;
      failures = 0;
      set_in(1'b1, 12'h000);
      test_reset();
      test_basic();
      test_frame6();
      test_frame3();
      test_timeout();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
